// File: rtl/mest_pro_seq_ctrl.sv
// mest_pro_seq_ctrl: fetch/execute sequencer for a small microprogram store.
// Latency: 3 cycles minimum per instruction (FETCH + EXEC + WAIT when memory and execute unit answer at once).
// Backpressure: FETCH holds o_imem_req until i_imem_valid; WAIT stalls until i_exec_done or the timeout fires.
//
// Ports:
//   clk, i_reset                      clock, synchronous active-high reset
//   i_start                           begin at PC 0 (only from IDLE or HALT)
//   o_imem_req/o_imem_addr            instruction fetch request and address (= PC)
//   i_imem_valid/i_imem_data          fetched instruction word {opcode, operand1, operand2}
//   o_op_code/o_operand1/o_operand2   latched fields for the execute unit
//   o_execute                         one-cycle execute strobe
//   i_exec_done + i_jump/i_return_pc/i_end_of_code   completion and control-flow flags
//   o_pc, o_busy, o_halted, o_error   status (error: 0 none, 1 overflow, 2 underflow, 3 timeout)
//
// Optional feature: define MEST_PRO_CALL_STACK_EN to enable the return-address
// stack (i_jump pushes PC+1, i_return_pc pops). Without it, i_jump only loads
// the PC and i_return_pc advances sequentially.

module mest_pro_seq_ctrl #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 24,
  parameter int STACK_DEPTH = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  output logic                   o_imem_req,
  output logic [PC_WIDTH-1:0]    o_imem_addr,
  input  logic                   i_imem_valid,
  input  logic [INSTR_WIDTH-1:0] i_imem_data,
  output logic [7:0]             o_op_code,
  output logic [7:0]             o_operand1,
  output logic [7:0]             o_operand2,
  output logic                   o_execute,
  input  logic                   i_exec_done,
  input  logic                   i_jump,
  input  logic                   i_return_pc,
  input  logic                   i_end_of_code,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic                   o_busy,
  output logic                   o_halted,
  output logic [1:0]             o_error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WAIT  = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_ONE  = 1;
  // The counter is 0 on the first WAIT cycle, so TIMEOUT-1 marks the last one.
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PC_WIDTH-1:0] PC_ONE   = 1;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [CNT_W-1:0]    cnt;

  // Natural wrap from all-ones to zero.
  assign pc_inc      = pc + PC_ONE;
  assign o_pc        = pc;
  assign o_imem_addr = pc;

`ifdef MEST_PRO_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_ONE  = 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]     sp;       // number of occupied entries
  logic [SP_W-1:0]     sp_top;   // index of the newest entry when non-empty
  logic                stack_full;
  logic                stack_empty;
  logic                push;

  assign sp_top      = sp - SP_ONE;
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  // A push happens only for a jump that wins the flag priority and has room.
  assign push = !i_reset && (state == WAIT) && i_exec_done && !i_end_of_code &&
                !i_return_pc && i_jump && !stack_full;

  // Stack contents need no reset: an empty stack is defined purely by sp.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[sp[PTR_W-1:0]] <= pc_inc;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state      <= IDLE;
      pc         <= '0;
      cnt        <= '0;
      o_error    <= ERR_NONE;
      o_imem_req <= 1'b0;
      o_execute  <= 1'b0;
      o_busy     <= 1'b0;
      o_halted   <= 1'b0;
      o_op_code  <= '0;
      o_operand1 <= '0;
      o_operand2 <= '0;
`ifdef MEST_PRO_CALL_STACK_EN
      sp         <= '0;
`endif
    end else begin
      case (state)
        IDLE, HALT: begin
          if (i_start) begin
            state      <= FETCH;
            pc         <= '0;
            o_error    <= ERR_NONE;
            o_imem_req <= 1'b1;
            o_busy     <= 1'b1;
            o_halted   <= 1'b0;
`ifdef MEST_PRO_CALL_STACK_EN
            sp         <= '0;
`endif
          end
        end

        FETCH: begin
          if (i_imem_valid) begin
            o_op_code  <= i_imem_data[23:16];
            o_operand1 <= i_imem_data[15:8];
            o_operand2 <= i_imem_data[7:0];
            o_imem_req <= 1'b0;
            o_execute  <= 1'b1;
            state      <= EXEC;
          end
        end

        EXEC: begin
          o_execute <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end

        WAIT: begin
          if (i_exec_done) begin
            if (i_end_of_code) begin
              state    <= HALT;
              o_busy   <= 1'b0;
              o_halted <= 1'b1;
            end else if (i_return_pc) begin
`ifdef MEST_PRO_CALL_STACK_EN
              if (stack_empty) begin
                o_error  <= ERR_UNDERFLOW;
                state    <= HALT;
                o_busy   <= 1'b0;
                o_halted <= 1'b1;
              end else begin
                pc         <= stack_mem[sp_top[PTR_W-1:0]];
                sp         <= sp_top;
                state      <= FETCH;
                o_imem_req <= 1'b1;
              end
`else
              pc         <= pc_inc;
              state      <= FETCH;
              o_imem_req <= 1'b1;
`endif
            end else if (i_jump) begin
`ifdef MEST_PRO_CALL_STACK_EN
              if (stack_full) begin
                o_error  <= ERR_OVERFLOW;
                state    <= HALT;
                o_busy   <= 1'b0;
                o_halted <= 1'b1;
              end else begin
                pc         <= PC_WIDTH'(o_operand2);
                sp         <= sp + SP_ONE;
                state      <= FETCH;
                o_imem_req <= 1'b1;
              end
`else
              pc         <= PC_WIDTH'(o_operand2);
              state      <= FETCH;
              o_imem_req <= 1'b1;
`endif
            end else begin
              pc         <= pc_inc;
              state      <= FETCH;
              o_imem_req <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            o_error  <= ERR_TIMEOUT;
            state    <= HALT;
            o_busy   <= 1'b0;
            o_halted <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state      <= IDLE;
          o_imem_req <= 1'b0;
          o_execute  <= 1'b0;
          o_busy     <= 1'b0;
          o_halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mest_pro_seq_ctrl.sv
// tb_mest_pro_seq_ctrl: directed plus randomized program runs against a queue-based program model.
// Latency: n/a (testbench).
// Backpressure: memory valid and execute done are delayed by random cycle counts.

module tb_mest_pro_seq_ctrl;

  localparam int TMO   = 255;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_imem_valid, i_exec_done;
  logic        i_jump, i_return_pc, i_end_of_code;
  logic [23:0] i_imem_data;
  logic        o_imem_req, o_execute, o_busy, o_halted;
  logic [7:0]  o_imem_addr, o_op_code, o_operand1, o_operand2, o_pc;
  logic [1:0]  o_error;

  always #5 clk = ~clk;

  mest_pro_seq_ctrl #(
    .PC_WIDTH(8), .INSTR_WIDTH(24), .STACK_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_start(i_start),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_valid(i_imem_valid), .i_imem_data(i_imem_data),
    .o_op_code(o_op_code), .o_operand1(o_operand1), .o_operand2(o_operand2),
    .o_execute(o_execute), .i_exec_done(i_exec_done),
    .i_jump(i_jump), .i_return_pc(i_return_pc), .i_end_of_code(i_end_of_code),
    .o_pc(o_pc), .o_busy(o_busy), .o_halted(o_halted), .o_error(o_error)
  );

  int total = 0;
  int bad   = 0;
  int n_exec = 0;

  // Program store and architectural model of the sequencer.
  logic [23:0] mem [256];
  logic [23:0] cur;
  logic [7:0]  m_pc;
  logic [1:0]  m_err;
  bit          m_halt;
  logic [7:0]  m_stack [$];

  always @(negedge clk) if (o_execute) n_exec++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_restart();
    m_pc   = 8'h00;
    m_err  = 2'd0;
    m_halt = 1'b0;
    m_stack.delete();
  endtask

  // Next-PC rules applied to the instruction in 'cur' at m_pc.
  task automatic model_step(input bit jmp, input bit ret, input bit eoc);
    logic [7:0] nxt;
    nxt = m_pc + 8'd1;
    if (eoc) begin
      m_halt = 1'b1;
    end else if (ret) begin
`ifdef MEST_PRO_CALL_STACK_EN
      if (m_stack.size() == 0) begin
        m_err = 2'd2; m_halt = 1'b1;
      end else begin
        m_pc = m_stack.pop_back();
      end
`else
      m_pc = nxt;
`endif
    end else if (jmp) begin
`ifdef MEST_PRO_CALL_STACK_EN
      if (m_stack.size() == DEPTH) begin
        m_err = 2'd1; m_halt = 1'b1;
      end else begin
        m_stack.push_back(nxt);
        m_pc = cur[7:0];
      end
`else
      m_pc = cur[7:0];
`endif
    end else begin
      m_pc = nxt;
    end
  endtask

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    model_restart();
    chk("start_busy", o_busy, 1);
    chk("start_pc", o_pc, m_pc);
    chk("start_err", o_error, 0);
    chk("start_halted", o_halted, 0);
  endtask

  // From FETCH to the first WAIT cycle; optional noise injects ignored inputs.
  task automatic fetch_exec(input int vdly, input bit noise);
    chk("fetch_req", o_imem_req, 1);
    chk("fetch_addr", o_imem_addr, m_pc);
    for (int i = 0; i < vdly; i++) begin
      if (noise) begin i_exec_done = 1'b1; i_end_of_code = 1'b1; end
      tick();
      i_exec_done = 1'b0; i_end_of_code = 1'b0;
      chk("fetch_hold", {o_imem_req, o_busy, o_execute}, 3'b110);
    end
    cur = mem[m_pc];
    i_imem_data  = cur;
    i_imem_valid = 1'b1;
    tick();
    i_imem_valid = 1'b0;
    i_imem_data  = 24'($urandom);
    chk("exec_strobe", o_execute, 1);
    chk("exec_req", o_imem_req, 0);
    chk("fields", {o_op_code, o_operand1, o_operand2}, cur);
    if (noise) i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("wait_strobe_low", o_execute, 0);
    chk("wait_pc", o_pc, m_pc);
    chk("wait_busy", o_busy, 1);
  endtask

  task automatic finish_wait(input int ddly, input bit jmp, input bit ret, input bit eoc);
    for (int i = 0; i < ddly; i++) tick();
    i_exec_done = 1'b1; i_jump = jmp; i_return_pc = ret; i_end_of_code = eoc;
    tick();
    i_exec_done = 1'b0; i_jump = 1'b0; i_return_pc = 1'b0; i_end_of_code = 1'b0;
    model_step(jmp, ret, eoc);
    chk("done_halted", o_halted, m_halt);
    chk("done_pc", o_pc, m_pc);
    chk("done_err", o_error, m_err);
    chk("done_req", o_imem_req, !m_halt);
    chk("done_busy", o_busy, !m_halt);
  endtask

  task automatic do_instr(input int vdly, input int ddly, input bit noise,
                          input bit jmp, input bit ret, input bit eoc);
    fetch_exec(vdly, noise);
    finish_wait(ddly, jmp, ret, eoc);
  endtask

  initial begin
    int base;
    i_reset = 1'b1; i_start = 1'b0; i_imem_valid = 1'b0; i_imem_data = '0;
    i_exec_done = 1'b0; i_jump = 1'b0; i_return_pc = 1'b0; i_end_of_code = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
    model_restart();

    // Reset state
    tick(); tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_halted", o_halted, 0);
    chk("rst_req", o_imem_req, 0);
    chk("rst_exec", o_execute, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_addr", o_imem_addr, 0);
    chk("rst_err", o_error, 0);
    chk("rst_fields", {o_op_code, o_operand1, o_operand2}, 0);
    i_reset = 1'b0;
    tick();
    chk("idle_hold", {o_busy, o_halted}, 0);

    // ADD, ADD, HALT with one-cycle memory and execute responses
    mem[0] = 24'h01_1122; mem[1] = 24'h01_3344; mem[2] = 24'hFF_0000;
    do_start();
    base = n_exec;
    do_instr(1, 0, 0, 0, 0, 0);
    do_instr(1, 0, 0, 0, 0, 0);
    do_instr(1, 0, 0, 0, 0, 1);
    chk("prog_exec_pulses", n_exec - base, 3);
    chk("prog_final_pc", o_pc, 8'd2);

    // Jump, return, jump to 0xFF, sequential wrap, end
    mem[3]  = 24'h20_0010;
    mem[4]  = 24'h20_00FF;
    mem[17] = 24'h20_00FF;
    do_start();
    do_instr(0, 1, 1, 0, 0, 0);
    do_instr(2, 0, 1, 0, 0, 0);
    do_instr(1, 2, 0, 0, 0, 0);
    do_instr(0, 0, 0, 1, 0, 0);
    chk("jump_addr", o_imem_addr, 8'h10);
    do_instr(1, 1, 0, 0, 1, 0);
`ifdef MEST_PRO_CALL_STACK_EN
    chk("return_addr", o_imem_addr, 8'h04);
`else
    chk("return_addr", o_imem_addr, 8'h11);
`endif
    do_instr(0, 0, 0, 1, 0, 0);
    chk("jump_ff_addr", o_imem_addr, 8'hFF);
    do_instr(0, 0, 0, 0, 0, 0);
    chk("wrap_addr", o_imem_addr, 8'h00);
    do_instr(0, 0, 0, 0, 0, 1);

`ifdef MEST_PRO_CALL_STACK_EN
    // Five nested calls overflow a four-entry stack
    do_start();
    for (int k = 0; k < 5; k++) begin
      mem[m_pc] = {16'h3000, 8'(8'h20 + k)};
      do_instr(0, 0, 0, 1, 0, 0);
    end
    chk("ovf_err", o_error, 2'd1);
    chk("ovf_halted", o_halted, 1);
    do_start();
    // Return with an empty stack underflows
    do_instr(0, 0, 0, 0, 1, 0);
    chk("unf_err", o_error, 2'd2);
`endif

    // Execute-unit timeout
    do_start();
    fetch_exec(0, 0);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (k == TMO - 1) chk("tmo_not_yet", {o_halted, o_error}, 3'b000);
    end
    chk("tmo_halted", o_halted, 1);
    chk("tmo_err", o_error, 2'd3);
    chk("tmo_pc", o_pc, m_pc);
    // Done in HALT is ignored
    i_exec_done = 1'b1; i_jump = 1'b1;
    tick();
    i_exec_done = 1'b0; i_jump = 1'b0;
    chk("halt_ignore_done", {o_halted, o_error, o_pc}, {1'b1, 2'd3, m_pc});

    // Reset in WAIT, together with start and done
    do_start();
    do_instr(0, 0, 0, 0, 0, 0);
    fetch_exec(0, 0);
    i_reset = 1'b1; i_start = 1'b1; i_exec_done = 1'b1;
    tick();
    i_reset = 1'b0; i_start = 1'b0; i_exec_done = 1'b0;
    chk("wrst_busy", o_busy, 0);
    chk("wrst_pc", o_pc, 0);
    chk("wrst_ctrl", {o_imem_req, o_execute, o_halted, o_error}, 0);
    chk("wrst_fields", {o_op_code, o_operand1, o_operand2}, 0);
    tick();
    chk("wrst_idle", o_busy, 0);

    // Randomized programs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
      do_start();
      for (int n = 0; n < 30 && !m_halt; n++) begin
        do_instr($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0);
      end
      if (!m_halt) begin
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rand_rst_busy", o_busy, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mest_pro_seq_ctrl.md
MEST_PRO_SEQ_CTRL -- requirements
Module: mest_pro_seq_ctrl

Interface
REQ-001 Parameter: PC_WIDTH, default 8, program counter and instruction-memory address width.
REQ-002 Parameter: INSTR_WIDTH, default 24, instruction word: [23:16] opcode, [15:8] operand1, [7:0] operand2.
REQ-003 Parameter: STACK_DEPTH, default 4, return-address stack entries.
REQ-004 Parameter: TIMEOUT, default 255, maximum cycles from o_execute to i_exec_done.
REQ-005 Port: clk  in  1  rising-edge clock, sole clock domain.
REQ-006 Port: i_reset  in  1  synchronous, active-high reset.
REQ-007 Port: i_start  in  1  begin execution at PC 0; honoured only in IDLE or HALT.
REQ-008 Port: o_imem_req  out  1  instruction fetch request.
REQ-009 Port: o_imem_addr  out  PC_WIDTH  fetch address; equals current PC.
REQ-010 Port: i_imem_valid  in  1  i_imem_data valid this cycle.
REQ-011 Port: i_imem_data  in  INSTR_WIDTH  fetched instruction.
REQ-012 Port: o_op_code / o_operand1 / o_operand2  out  8/8/8  latched instruction fields to execute unit.
REQ-013 Port: o_execute  out  1  one-cycle execute strobe.
REQ-014 Port: i_exec_done  in  1  execute unit completion.
REQ-015 Port: i_jump / i_return_pc / i_end_of_code  in  1 each  execute unit control flags; sampled only when i_exec_done=1.
REQ-016 Port: o_pc  out  PC_WIDTH  current PC.
REQ-017 Port: o_busy  out  1  high in FETCH, EXEC and WAIT.
REQ-018 Port: o_halted  out  1  high in HALT.
REQ-019 Port: o_error  out  2  sticky: 0 none, 1 stack overflow, 2 stack underflow, 3 timeout.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, EXEC, WAIT, HALT.
REQ-021 IDLE/HALT with i_start=1: next cycle PC=0, stack emptied, o_error=0, state FETCH.
REQ-022 FETCH: o_imem_req=1 held until i_imem_valid=1; on valid, fields latched into o_op_code/o_operand1/o_operand2, state EXEC.
REQ-023 EXEC: o_execute=1 for exactly one cycle, timeout counter cleared, state WAIT.
REQ-024 WAIT: counter increments each cycle; when i_exec_done=1, next PC is chosen by priority i_end_of_code > i_return_pc > i_jump > sequential.
REQ-025 i_end_of_code: PC unchanged, state HALT.
REQ-026 i_jump: PC=o_operand2 zero-extended to PC_WIDTH, state FETCH.
REQ-027 Sequential: PC=PC+1 modulo 2^PC_WIDTH (wraps from all-ones to 0), state FETCH.
REQ-028 Minimum instruction latency: FETCH(1, valid in the same cycle) + EXEC(1) + WAIT(1, done on the first WAIT cycle) = 3 cycles.
REQ-029 Counter reaching TIMEOUT without i_exec_done: o_error=3, state HALT.
REQ-030 i_exec_done outside WAIT SHALL be ignored.
REQ-031 i_start while busy SHALL be ignored.
REQ-032 o_error is written only on the transition into HALT and is otherwise held.

Reset
REQ-033 i_reset=1 at a clock edge from any state, including mid-fetch or mid-execute: state IDLE, PC=0, stack empty, counter=0, o_error=0, o_imem_req=0, o_execute=0, latched fields=0.
REQ-034 Reset SHALL take priority over i_start and every other input in the same cycle.

Configuration
REQ-035 Macro MEST_PRO_CALL_STACK_EN defined: i_jump pushes PC+1 (wrapped) onto the stack.
REQ-036 MEST_PRO_CALL_STACK_EN defined: i_return_pc pops the stack into PC.
REQ-037 MEST_PRO_CALL_STACK_EN defined: a push with the stack full gives o_error=1 and HALT with PC unchanged.
REQ-038 MEST_PRO_CALL_STACK_EN defined: a pop with the stack empty gives o_error=2 and HALT with PC unchanged.
REQ-039 Macro undefined: no stack storage; i_jump only loads the PC; i_return_pc behaves as sequential PC+1; o_error is never 1 or 2.

Verification
REQ-040 Reset, i_start, program ADD, ADD, HALT with i_imem_valid and i_exec_done each asserted one cycle after their request/strobe -> o_pc 0,1,2; three o_execute pulses; o_halted=1 with o_pc=2, o_error=0.
REQ-041 Jump at PC 3 with operand2=0x10 -> next o_imem_addr=0x10; with the macro defined, 0x10 issues a return -> next o_imem_addr=0x04.
REQ-042 Macro defined, five nested jumps with STACK_DEPTH=4 -> after the 5th done, o_error=1, o_halted=1; then i_start -> o_pc=0, o_error=0.
REQ-043 i_exec_done held low after o_execute with TIMEOUT=255 -> HALT exactly 255 cycles after WAIT entry, o_error=3.
REQ-044 PC=0xFF, sequential instruction -> next o_imem_addr=0x00; i_reset asserted in WAIT -> IDLE next cycle, o_busy=0, o_pc=0.
